// File: rtl/muldiv_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_hilo_ctrl
//
// Owns the architectural HI/LO register pair. It sequences MULT/MULTU/DIV/DIVU/
// MTHI/MTLO operations issued from the EX stage.
//   - MULT/MULTU commit the external combinational product in the accept cycle.
//     They cause no stall.
//   - MTHI/MTLO write one half of the pair in the accept cycle.
//   - DIV/DIVU latch their operands. The block then hands them to a multi-cycle
//     divider core through a valid/ready handshake and waits for the one-cycle
//     result pulse. A flush during an in-flight divide discards the result.
//     If the handshake already completed, DRAIN swallows the pulse that is
//     still coming.
//   - A watchdog abandons a divide that never returns a result. In that case
//     it raises a sticky timeout flag.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       EX request handshake
//   req_op                    0 MULT 1 MULTU 2 DIV 3 DIVU 4 MTHI 5 MTLO
//                             (6 and 7 are accepted and have no effect)
//   req_src1, req_src2        operands
//   flush                     kills a presented or in-flight op
//   mul_op                    multiplier mode: bit0 signed, bit1 unsigned
//   mul_src1, mul_src2        operand pass-through to the multiplier
//   mul_result                combinational 64-bit product
//   div_signed                selects the signed divider channel
//   div_dividend/div_divisor  latched divide operands
//   div_src_valid/ready       divider source handshake
//   div_dout_valid/data       divider result pulse: {quotient, remainder}
//   hi, lo                    architectural HI/LO
//   busy                      controller is not idle (EX stall)
//   div_done                  one-cycle pulse after a divide commits
//   div_timeout               sticky watchdog flag, cleared only by rst
// -----------------------------------------------------------------------------
module muldiv_hilo_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic [1:0]  mul_op,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [63:0] mul_result,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_src_valid,
  input  logic        div_src_ready,
  input  logic        div_dout_valid,
  input  logic [63:0] div_dout_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        div_done,
  output logic        div_timeout
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // This is the last counter value in WAIT/DRAIN before the divide is abandoned.
  // The counter is cleared on entry, so this gives exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [31:0]       hi_reg, hi_next;
  logic [31:0]       lo_reg, lo_next;
  logic [31:0]       dividend_reg, dividend_next;
  logic [31:0]       divisor_reg, divisor_next;
  logic              signed_reg, signed_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              done_reg, done_next;
  logic              timeout_reg, timeout_next;

  logic              accept;
  logic              cnt_expired;

  // A request presented during a flush is not accepted.
  assign req_ready   = (state_reg == IDLE) && !flush;
  assign accept      = req_valid && req_ready;
  assign cnt_expired = (cnt_reg == CNT_LAST);

  // -------------------------------------------------------------------------
  // Multiplier interface
  // -------------------------------------------------------------------------
  assign mul_src1 = req_src1;
  assign mul_src2 = req_src2;

  always_comb begin
    mul_op = 2'b00;
    if (req_valid && (state_reg == IDLE)) begin
      if (req_op == OP_MULT) begin
        mul_op = 2'b01;
      end else if (req_op == OP_MULTU) begin
        mul_op = 2'b10;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath updates
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    dividend_next = dividend_reg;
    divisor_next  = divisor_reg;
    signed_next   = signed_reg;
    cnt_next      = cnt_reg;
    done_next     = 1'b0;
    timeout_next  = timeout_reg;

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          case (req_op)
            OP_MULT, OP_MULTU: begin
              hi_next = mul_result[63:32];
              lo_next = mul_result[31:0];
            end
            OP_DIV, OP_DIVU: begin
              dividend_next = req_src1;
              divisor_next  = req_src2;
              signed_next   = (req_op == OP_DIV);
              state_next    = ISSUE;
            end
            OP_MTHI: hi_next = req_src1;
            OP_MTLO: lo_next = req_src1;
            default: ;  // reserved ops are consumed without effect
          endcase
        end
      end

      ISSUE: begin
        if (div_src_ready) begin
          // The core has taken the operands, so a result pulse will come.
          // After a flush it must be drained instead of committed.
          cnt_next   = '0;
          state_next = flush ? DRAIN : WAIT;
        end else if (flush) begin
          state_next = IDLE;
        end
      end

      WAIT: begin
        if (flush) begin
          // If the result arrives on the flush cycle, nothing is left to drain.
          cnt_next   = '0;
          state_next = div_dout_valid ? IDLE : DRAIN;
        end else if (div_dout_valid) begin
          // Core packs {quotient, remainder}; LO takes quotient, HI remainder.
          lo_next    = div_dout_data[63:32];
          hi_next    = div_dout_data[31:0];
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (cnt_expired) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DRAIN: begin
        if (div_dout_valid) begin
          state_next = IDLE;
        end else if (cnt_expired) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      hi_reg       <= '0;
      lo_reg       <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      signed_reg   <= 1'b0;
      cnt_reg      <= '0;
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      dividend_reg <= dividend_next;
      divisor_reg  <= divisor_next;
      signed_reg   <= signed_next;
      cnt_reg      <= cnt_next;
      done_reg     <= done_next;
      timeout_reg  <= timeout_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign hi            = hi_reg;
  assign lo            = lo_reg;
  assign div_dividend  = dividend_reg;
  assign div_divisor   = divisor_reg;
  assign div_signed    = signed_reg;
  assign div_src_valid = (state_reg == ISSUE);
  assign busy          = (state_reg != IDLE);
  assign div_done      = done_reg;
  assign div_timeout   = timeout_reg;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
module tb_muldiv_hilo_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic [1:0]  mul_op;
  logic [31:0] mul_src1;
  logic [31:0] mul_src2;
  logic [63:0] mul_result;
  logic        div_signed;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_src_valid;
  logic        div_src_ready;
  logic        div_dout_valid;
  logic [63:0] div_dout_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        div_done;
  logic        div_timeout;

  int total;
  int bad;

  muldiv_hilo_ctrl #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_src1       (req_src1),
    .req_src2       (req_src2),
    .flush          (flush),
    .mul_op         (mul_op),
    .mul_src1       (mul_src1),
    .mul_src2       (mul_src2),
    .mul_result     (mul_result),
    .div_signed     (div_signed),
    .div_dividend   (div_dividend),
    .div_divisor    (div_divisor),
    .div_src_valid  (div_src_valid),
    .div_src_ready  (div_src_ready),
    .div_dout_valid (div_dout_valid),
    .div_dout_data  (div_dout_data),
    .hi             (hi),
    .lo             (lo),
    .busy           (busy),
    .div_done       (div_done),
    .div_timeout    (div_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL reset_hilo: hi=%h lo=%h required 0/0", hi, lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    total++; if (div_done !== 1'b0 || div_timeout !== 1'b0) begin bad++; $display("FAIL reset_flags: done=%b timeout=%b required 0/0", div_done, div_timeout); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b required 1", req_ready); end
    total++; if (div_dividend !== 32'h0 || div_divisor !== 32'h0 || div_src_valid !== 1'b0) begin bad++; $display("FAIL reset_div: dvd=%h dvs=%h sv=%b required 0", div_dividend, div_divisor, div_src_valid); end
    $display("reset: hi=%h lo=%h busy=%b", hi, lo, busy);
  endtask

  task automatic test_mult();
    // MULTU 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    req_valid = 1'b1; req_op = 3'd1; req_src1 = 32'hFFFF_FFFF; req_src2 = 32'd2;
    mul_result = 64'h0000_0001_FFFF_FFFE;
    #1;
    total++; if (mul_op !== 2'b10) begin bad++; $display("FAIL multu_mul_op: got %b required 10", mul_op); end
    total++; if (mul_src1 !== 32'hFFFF_FFFF || mul_src2 !== 32'd2) begin bad++; $display("FAIL multu_src: got %h %h", mul_src1, mul_src2); end
    tick();
    req_valid = 1'b0;
    #1;
    total++; if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hilo: hi=%h lo=%h required 00000001/fffffffe", hi, lo); end
    total++; if (busy !== 1'b0 || mul_op !== 2'b00) begin bad++; $display("FAIL multu_busy: busy=%b mul_op=%b required 0/00", busy, mul_op); end
    $display("multu: hi=%h lo=%h", hi, lo);
    // MULT -3 * 5 = -15
    req_valid = 1'b1; req_op = 3'd0; req_src1 = 32'hFFFF_FFFD; req_src2 = 32'd5;
    mul_result = 64'hFFFF_FFFF_FFFF_FFF1;
    #1;
    total++; if (mul_op !== 2'b01) begin bad++; $display("FAIL mult_mul_op: got %b required 01", mul_op); end
    tick();
    req_valid = 1'b0;
    total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_hilo: hi=%h lo=%h required ffffffff/fffffff1", hi, lo); end
    $display("mult: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_div_signed();
    int pulses;
    req_valid = 1'b1; req_op = 3'd2; req_src1 = 32'hFFFF_FFF9; req_src2 = 32'd2;
    #1;
    total++; if (mul_op !== 2'b00) begin bad++; $display("FAIL div_mul_op: got %b required 00", mul_op); end
    tick();
    req_valid = 1'b0;
    #1;
    total++; if (busy !== 1'b1 || div_src_valid !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL div_issue: busy=%b sv=%b rdy=%b required 1/1/0", busy, div_src_valid, req_ready); end
    total++; if (div_signed !== 1'b1 || div_dividend !== 32'hFFFF_FFF9 || div_divisor !== 32'd2) begin bad++; $display("FAIL div_operands: s=%b dvd=%h dvs=%h required 1/fffffff9/00000002", div_signed, div_dividend, div_divisor); end
    div_src_ready = 1'b1;
    tick();
    div_src_ready = 1'b0;
    #1;
    total++; if (div_src_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL div_wait_entry: sv=%b busy=%b required 0/1", div_src_valid, busy); end
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      total++; if (busy !== 1'b1 || div_done !== 1'b0) begin bad++; $display("FAIL div_wait_busy: cyc=%0d busy=%b done=%b required 1/0", i, busy, div_done); end
      tick();
    end
    div_dout_valid = 1'b1; div_dout_data = {32'hFFFF_FFFD, 32'hFFFF_FFFF};
    tick();
    div_dout_valid = 1'b0; div_dout_data = 64'h0;
    total++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hilo: hi=%h lo=%h required ffffffff/fffffffd", hi, lo); end
    total++; if (div_done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL div_commit: done=%b busy=%b required 1/0", div_done, busy); end
    if (div_done === 1'b1) pulses++;
    tick();
    if (div_done === 1'b1) pulses++;
    total++; if (pulses !== 1) begin bad++; $display("FAIL div_done_width: got %0d cycles required 1", pulses); end
    $display("div: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_divu_flush_wait();
    req_valid = 1'b1; req_op = 3'd3; req_src1 = 32'd100; req_src2 = 32'd7;
    tick();
    req_valid = 1'b0;
    total++; if (div_signed !== 1'b0) begin bad++; $display("FAIL divu_signed: got %b required 0", div_signed); end
    div_src_ready = 1'b1;
    tick();
    div_src_ready = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (busy !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL divu_drain_busy: cyc=%0d busy=%b rdy=%b required 1/0", i, busy, req_ready); end
      tick();
    end
    div_dout_valid = 1'b1; div_dout_data = {32'd14, 32'd2};
    tick();
    div_dout_valid = 1'b0; div_dout_data = 64'h0;
    total++; if (busy !== 1'b0 || req_ready !== 1'b1 || div_done !== 1'b0) begin bad++; $display("FAIL divu_drain_exit: busy=%b rdy=%b done=%b required 0/1/0", busy, req_ready, div_done); end
    total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL divu_flush_hilo: hi=%h lo=%h required ffffffff/fffffffd", hi, lo); end
    tick();
    total++; if (div_done !== 1'b0) begin bad++; $display("FAIL divu_flush_done: got %b required 0", div_done); end
    $display("divu flush in wait: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_flush_issue();
    // Flush in ISSUE without ready: straight back to IDLE.
    req_valid = 1'b1; req_op = 3'd3; req_src1 = 32'd50; req_src2 = 32'd5;
    tick();
    req_valid = 1'b0;
    total++; if (div_src_valid !== 1'b1) begin bad++; $display("FAIL issue_valid: got %b required 1", div_src_valid); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || div_src_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL issue_flush: busy=%b sv=%b rdy=%b required 0/0/1", busy, div_src_valid, req_ready); end
    // Request presented during flush is dropped.
    req_valid = 1'b1; req_op = 3'd4; req_src1 = 32'hDEAD_BEEF; flush = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b required 0", req_ready); end
    tick();
    req_valid = 1'b0; flush = 1'b0;
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL flush_drop: hi=%h required ffffffff", hi); end
    // Flush together with ready in ISSUE: handshake done, so DRAIN.
    req_valid = 1'b1; req_op = 3'd2; req_src1 = 32'd9; req_src2 = 32'd3;
    tick();
    req_valid = 1'b0;
    div_src_ready = 1'b1; flush = 1'b1;
    tick();
    div_src_ready = 1'b0; flush = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL issue_drain: busy=%b required 1", busy); end
    div_dout_valid = 1'b1; div_dout_data = {32'd3, 32'd0};
    tick();
    div_dout_valid = 1'b0;
    total++; if (busy !== 1'b0 || lo !== 32'hFFFF_FFFD || div_done !== 1'b0) begin bad++; $display("FAIL issue_drain_exit: busy=%b lo=%h done=%b required 0/fffffffd/0", busy, lo, div_done); end
    $display("flush in issue: busy=%b sv=%b", busy, div_src_valid);
  endtask

  task automatic test_timeout();
    req_valid = 1'b1; req_op = 3'd2; req_src1 = 32'd1; req_src2 = 32'd1;
    tick();
    req_valid = 1'b0;
    div_src_ready = 1'b1;
    tick();
    div_src_ready = 1'b0;
    for (int i = 0; i < 63; i++) begin
      total++; if (busy !== 1'b1 || div_timeout !== 1'b0) begin bad++; $display("FAIL timeout_wait: cyc=%0d busy=%b to=%b required 1/0", i, busy, div_timeout); end
      tick();
    end
    total++; if (busy !== 1'b1 || div_timeout !== 1'b0) begin bad++; $display("FAIL timeout_last: busy=%b to=%b required 1/0", busy, div_timeout); end
    tick();
    total++; if (div_timeout !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL timeout_fire: to=%b busy=%b required 1/0", div_timeout, busy); end
    total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL timeout_hilo: hi=%h lo=%h required ffffffff/fffffffd", hi, lo); end
    $display("timeout: to=%b busy=%b", div_timeout, busy);
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_op = 3'd4; req_src1 = 32'h1234_5678;
    tick();
    total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi: hi=%h required 12345678", hi); end
    req_op = 3'd5; req_src1 = 32'h9ABC_DEF0;
    tick();
    total++; if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678) begin bad++; $display("FAIL mtlo: hi=%h lo=%h required 12345678/9abcdef0", hi, lo); end
    req_op = 3'd6; req_src1 = 32'h5555_5555;
    #1;
    total++; if (req_ready !== 1'b1 || mul_op !== 2'b00) begin bad++; $display("FAIL op6_ready: rdy=%b mul_op=%b required 1/00", req_ready, mul_op); end
    tick();
    req_op = 3'd7;
    tick();
    req_valid = 1'b0;
    total++; if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || busy !== 1'b0) begin bad++; $display("FAIL op67_noeffect: hi=%h lo=%h busy=%b", hi, lo, busy); end
    total++; if (div_timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b required 1", div_timeout); end
    $display("mthi/mtlo: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 1'b1; req_op = 3'd3; req_src1 = 32'd77; req_src2 = 32'd7;
    tick();
    req_valid = 1'b0;
    div_src_ready = 1'b1;
    tick();
    div_src_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin bad++; $display("FAIL rst_wait: hi=%h lo=%h busy=%b required 0/0/0", hi, lo, busy); end
    total++; if (div_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout_clear: got %b required 0", div_timeout); end
    div_dout_valid = 1'b1; div_dout_data = {32'd11, 32'd0};
    tick();
    div_dout_valid = 1'b0;
    total++; if (hi !== 32'h0 || lo !== 32'h0 || div_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_late_dout: hi=%h lo=%h done=%b busy=%b required 0/0/0/0", hi, lo, div_done, busy); end
    $display("reset mid wait: hi=%h lo=%h busy=%b", hi, lo, busy);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 3'd0;
    req_src1 = 32'h0;
    req_src2 = 32'h0;
    flush = 1'b0;
    mul_result = 64'h0;
    div_src_ready = 1'b0;
    div_dout_valid = 1'b0;
    div_dout_data = 64'h0;
    test_reset();
    test_mult();
    test_div_signed();
    test_divu_flush_wait();
    test_flush_issue();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
Owns the HI/LO register pair and sequences the multi-cycle divider core for MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the EX stage. Multiplies use the single-cycle combinational multiplier and commit immediately. Divides are launched to the divider core through a valid/ready source handshake, and the block waits for the result. Provides a busy stall to EX and handles pipeline flush (exception) during an in-flight divide.

Parameters:
TIMEOUT, 64, max cycles in WAIT before the divide is abandoned; must be at least 2.
CNT_W, 7, width of the WAIT cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  EX presents an op
req_ready  out  1  op accepted when req_valid && req_ready
req_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 ignored (accepted, no effect)
req_src1  in  32  rs / dividend / MTHI-MTLO data
req_src2  in  32  rt / divisor
flush  in  1  kill in-flight or presented op
mul_op  out  2  to multiplier: bit0 signed, bit1 unsigned
mul_src1, mul_src2  out  32  pass-through of req_src1/2
mul_result  in  64  combinational product
div_signed  out  1  selects the signed core channel
div_dividend, div_divisor  out  32  latched operands
div_src_valid  out  1  both source channels valid
div_src_ready  in  1  both source channels ready
div_dout_valid  in  1  one-cycle result pulse
div_dout_data  in  64  [63:32] quotient, [31:0] remainder
hi, lo  out  32  architectural HI/LO
busy  out  1  state != IDLE
div_done  out  1  one-cycle pulse when a divide commits HI/LO
div_timeout  out  1  sticky timeout flag; cleared only by rst

Behaviour:
- Reset: state IDLE; hi, lo, div_timeout, div_done, and the WAIT counter are 0; latched operands are 0.
- req_ready = (state==IDLE) && !flush. A request presented while flush is high is dropped and changes no state.
- IDLE, accepted op:
  - MULT/MULTU: {hi,lo} <= mul_result at the same edge; stays IDLE (zero stall).
  - MTHI: hi <= req_src1. MTLO: lo <= req_src1.
  - DIV/DIVU: latch src1/src2 and the sign mode; next state ISSUE.
- mul_op is driven only while req_valid && state==IDLE and the op is MULT/MULTU; otherwise it is 0.
- ISSUE: div_src_valid=1.
  - div_src_ready, no flush: go to WAIT, counter cleared.
  - div_src_ready && flush: go to DRAIN (the handshake completed).
  - flush without ready: go to IDLE; div_src_valid drops the next cycle.
- WAIT: counter increments each cycle.
  - div_dout_valid, no flush: lo <= quotient, hi <= remainder, div_done=1 for that cycle, go to IDLE.
  - flush (with or without dout_valid): result discarded; go to IDLE if dout_valid was high that cycle, otherwise DRAIN.
  - counter reaches TIMEOUT-1 without dout_valid: div_timeout <= 1, go to IDLE; HI/LO unchanged.
- DRAIN: busy=1. The first div_dout_valid is discarded, then go to IDLE. Same TIMEOUT rule applies; the counter is cleared on entry.
- Divide by zero: the core result is committed unmodified (architecturally unpredictable).
- div_done is registered, asserted the cycle after commit, and lasts exactly 1 cycle. hi/lo are visible the cycle after the commit edge.
- rst in any state returns to IDLE the next edge. A core result arriving afterwards is ignored because IDLE does not sample dout.
- Divide latency = issue handshake cycles + core latency + 1 commit cycle. busy stays high from the cycle after DIV acceptance until the commit edge.

Test Plan:
- MULTU src1=0xFFFFFFFF, src2=2 -> next cycle hi=0x00000001, lo=0xFFFFFFFE; busy stays 0.
- DIV src1=-7 (0xFFFFFFF9), src2=2; core model with ready after 1 cycle and dout after 10 cycles returning quotient -3 and remainder -1 -> div_signed=1, busy high throughout, lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_done a single pulse.
- DIVU 100/7 with flush asserted 3 cycles into WAIT -> state DRAIN, busy held until the core's dout pulse, hi/lo unchanged, div_done never asserted, then req_ready=1.
- Flush in ISSUE with div_src_ready=0 -> IDLE the next cycle, div_src_valid=0, no core result expected.
- Core never returns dout -> div_timeout=1 after TIMEOUT cycles in WAIT, state IDLE, hi/lo unchanged. Flag persists until rst.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back -> hi=0x12345678, lo=0x9ABCDEF0. rst mid-WAIT -> hi=lo=0, busy=0, and a subsequent dout pulse is ignored.
